// File: rtl/alu_bit_serial_ctrl.sv
// Bit-serial operand sequencer around a 1-bit ALU result mux: shifts A/B LSB-first, gathers mux bits.
// Optional flags outputs (out_carry, out_zero) are enabled by defining ALU_FLAGS_EN.
module alu_bit_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [2:0]       mux_op,
  output logic             mux_dhe,
  output logic             mux_ose,
  output logic             mux_xor1,
  output logic             mux_sum,
  input  logic             mux_dalja,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal
`ifdef ALU_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_zero
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             illegal_q, illegal_d;
  logic             a_bit, b_bit, shifting;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_ADD);
  endfunction

  assign shifting = (state_q == SHIFT);
  assign a_bit    = a_q[0];
  assign b_bit    = b_q[0];

  // Mux candidates are forced low outside SHIFT so the mux sees no stale operand bits.
  assign mux_op   = op_q;
  assign mux_dhe  = shifting & (a_bit & b_bit);
  assign mux_ose  = shifting & (a_bit | b_bit);
  assign mux_xor1 = shifting & (a_bit ^ b_bit);
  assign mux_sum  = shifting & (a_bit ^ b_bit ^ carry_q);

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_result  = result_q;
  assign out_illegal = illegal_q;

`ifdef ALU_FLAGS_EN
  assign out_carry = out_valid & (op_q == OP_ADD) & carry_q;
  assign out_zero  = out_valid & (result_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = in_b;
          op_d      = in_op;
          carry_d   = 1'b0;
          cnt_d     = '0;
          illegal_d = ~op_is_legal(in_op);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        result_d = {mux_dalja, result_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        // Carry ripples for every op; only the ADD path consumes it.
        carry_d  = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
